scan_chain_driver: RTL and testbench

Test-side controller for a chain of scan-mux flops (functional input D0, scan input D1, select SD). It serially loads a pattern into the chain and pulses one functional capture cycle. It then unloads the captured chain contents into a parallel word. It sits between a BIST or test-access block and the scan-enable/scan-in/scan-out pins of a register chain.

---
 rtl/scan_chain_driver_if.sv | 25 ++
 rtl/scan_chain_driver.sv | 121 ++++++++++++
 tb/tb_scan_chain_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_driver_if.sv
// Signal bundle between the scan chain driver, its test-access host and the
// scan chain pins. The master side is the driver; the slave side is the
// environment (host plus chain).
interface scan_chain_driver_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 START;
  logic [CHAIN_LEN-1:0] LOAD_DATA;
  logic                 SO;
  logic                 SD;
  logic                 SI;
  logic [CHAIN_LEN-1:0] CAP_DATA;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    input  START, LOAD_DATA, SO,
    output SD, SI, CAP_DATA, BUSY, DONE
  );

  modport slave (
    output START, LOAD_DATA, SO,
    input  SD, SI, CAP_DATA, BUSY, DONE
  );
endinterface

// File: rtl/scan_chain_driver.sv
// Scan chain driver: serially loads a pattern into a scan-mux flop chain,
// pulses one functional capture cycle, then unloads the chain into CAP_DATA.
// Every output is a flop so SD can never glitch.
module scan_chain_driver #(
  parameter int   CHAIN_LEN = 16,
  parameter int   CNT_W     = 8,
  parameter logic FILL      = 1'b0
) (
  input  logic                CK,
  input  logic                RN,
  scan_chain_driver_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_FINISH
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  // Load phase: bits not yet driven on SI, MSB-aligned.
  // Unload phase: shift register collecting SO samples.
  logic [CHAIN_LEN-1:0] shadow_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic                 sd_q;
  logic                 si_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // Sequencer: one registered FSM drives every output pin directly.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      // NOTE: CAP_DATA is a plain register, not a memory, so it gets a reset
      // value; a reset mid-sequence therefore never leaves a partial result.
      cap_q    <= '0;
      sd_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every right-hand
      // side reads the pre-edge value regardless of statement order.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            // First bit goes straight to SI; the rest wait MSB-aligned.
            si_q     <= bus.LOAD_DATA[CHAIN_LEN-1];
            shadow_q <= {bus.LOAD_DATA[CHAIN_LEN-2:0], 1'b0};
            cnt_q    <= '0;
            sd_q     <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end

        S_LOAD: begin
          si_q     <= shadow_q[CHAIN_LEN-1];
          shadow_q <= {shadow_q[CHAIN_LEN-2:0], 1'b0};
          if (cnt_last) begin
            // Chain now holds the pattern; drop SD for the capture edge.
            sd_q    <= 1'b0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          sd_q    <= 1'b1;
          si_q    <= FILL;
          cnt_q   <= '0;
          state_q <= S_UNLOAD;
        end

        S_UNLOAD: begin
          // SO still shows the pre-shift tail flop, so the first sample is
          // chain position N-1 and ends up in the MSB after N shifts.
          shadow_q <= {shadow_q[CHAIN_LEN-2:0], bus.SO};
          if (cnt_last) begin
            cap_q   <= {shadow_q[CHAIN_LEN-2:0], bus.SO};
            sd_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_FINISH: begin
          // START is deliberately not looked at here.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.SD       = sd_q;
  assign bus.SI       = si_q;
  assign bus.CAP_DATA = cap_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: two instances (4- and 16-flop chains), each
// attached to a behavioural scan-mux chain whose functional input is selectable.
module tb_scan_chain_driver;

  localparam int N4   = 4;
  localparam int N16  = 16;
  localparam int TMAX = 64;

  logic CK = 1'b0;
  logic RN = 1'b0;
  always #5 CK = ~CK;

  int n_tests = 0;
  int n_fail  = 0;

  scan_chain_driver_if #(.CHAIN_LEN(N4))  bus4 ();
  scan_chain_driver_if #(.CHAIN_LEN(N16)) bus16 ();

  scan_chain_driver #(.CHAIN_LEN(N4), .CNT_W(8), .FILL(1'b0)) u_dut4 (
    .CK(CK), .RN(RN), .bus(bus4)
  );
  scan_chain_driver #(.CHAIN_LEN(N16), .CNT_W(8), .FILL(1'b0)) u_dut16 (
    .CK(CK), .RN(RN), .bus(bus16)
  );

  // Functional-input rule of the chain: 0 = invert, 1 = constant k, 2 = hold.
  int mode4 = 2;
  int mode16 = 2;
  logic [N4-1:0]  k4  = '0;
  logic [N16-1:0] k16 = '0;

  function automatic logic [15:0] d0_fn(input int mode, input logic [15:0] q,
                                        input logic [15:0] k);
    case (mode)
      0:       return ~q;
      1:       return k;
      default: return q;
    endcase
  endfunction

  // Behavioural scan chains: SD=1 shifts SI into position 0, else D0 capture.
  logic [N4-1:0]  chain4  = '0;
  logic [N16-1:0] chain16 = '0;
  always @(posedge CK) begin
    if (bus4.SD) chain4 <= {chain4[N4-2:0], bus4.SI};
    else         chain4 <= N4'(d0_fn(mode4, 16'(chain4), 16'(k4)));
  end
  always @(posedge CK) begin
    if (bus16.SD) chain16 <= {chain16[N16-2:0], bus16.SI};
    else          chain16 <= N16'(d0_fn(mode16, 16'(chain16), 16'(k16)));
  end
  assign bus4.SO  = chain4[N4-1];
  assign bus16.SO = chain16[N16-1];

  // Per-cycle traces, index 0 = cycle right after the START-accepting edge.
  logic [TMAX-1:0] sd_tr, busy_tr, done_tr, si_tr;
  logic [TMAX-1:0] e_sd, e_busy, e_done, e_si, si_mask;
  logic [15:0]     snap;

  task automatic drive(input int n, input logic st, input logic [15:0] ld);
    if (n == N4) begin
      bus4.START     = st;
      bus4.LOAD_DATA = N4'(ld);
    end else begin
      bus16.START     = st;
      bus16.LOAD_DATA = ld;
    end
  endtask

  task automatic sample(input int n, input int i);
    if (n == N4) begin
      sd_tr[i] = bus4.SD;  busy_tr[i] = bus4.BUSY;
      done_tr[i] = bus4.DONE; si_tr[i] = bus4.SI;
      if (i == 2*N4+1) snap = 16'(chain4);
    end else begin
      sd_tr[i] = bus16.SD;  busy_tr[i] = bus16.BUSY;
      done_tr[i] = bus16.DONE; si_tr[i] = bus16.SI;
      if (i == 2*N16+1) snap = chain16;
    end
  endtask

  function automatic logic [15:0] cap_of(input int n);
    return (n == N4) ? 16'(bus4.CAP_DATA) : bus16.CAP_DATA;
  endfunction

  // Raise START, then record len cycles; start_mask[i] is START after cycle i.
  task automatic run_trace(input int n, input logic [15:0] ld, input int len,
                           input logic [TMAX-1:0] start_mask);
    sd_tr = '0; busy_tr = '0; done_tr = '0; si_tr = '0; snap = 16'hxxxx;
    @(negedge CK);
    drive(n, 1'b1, ld);
    for (int i = 0; i < len; i++) begin
      @(negedge CK);
      sample(n, i);
      drive(n, start_mask[i], ld);
    end
    drive(n, 1'b0, ld);
  endtask

  // Expected pin behaviour for nseq sequences started every 2N+3 cycles:
  // N shift cycles, one capture cycle, N unload cycles, one DONE cycle, one idle.
  task automatic build_exp(input int n, input logic [15:0] ld, input int nseq);
    int p, m, r;
    p = 2*n + 3;
    e_sd = '0; e_busy = '0; e_done = '0; e_si = '0; si_mask = '0;
    for (int i = 0; i < TMAX; i++) begin
      m = i / p;
      r = i % p;
      if (m < nseq) begin
        e_sd[i]   = (r < n) || (r > n && r <= 2*n);
        e_busy[i] = (r <= 2*n);
        e_done[i] = (r == 2*n + 1);
        if (r < n) begin
          si_mask[i] = 1'b1;
          e_si[i]    = ld[n-1-r];
        end else if (r > n && r <= 2*n) begin
          si_mask[i] = 1'b1;
          e_si[i]    = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    RN = 1'b0;
    #12;
    n_tests++;
    if ({bus4.SD, bus4.SI, bus4.BUSY, bus4.DONE, bus4.CAP_DATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_n4: got %b expected all zero",
               {bus4.SD, bus4.SI, bus4.BUSY, bus4.DONE, bus4.CAP_DATA});
    end
    @(negedge CK);
    RN = 1'b1;
    repeat (2) @(negedge CK);
    n_tests++;
    if ({bus16.SD, bus16.SI, bus16.BUSY, bus16.DONE, bus16.CAP_DATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_n16: got %h expected all zero",
               {bus16.SD, bus16.SI, bus16.BUSY, bus16.DONE, bus16.CAP_DATA});
    end
  endtask

  task automatic test_invert();
    mode4 = 0;
    run_trace(N4, 16'h000A, 2*N4+4, '0);
    build_exp(N4, 16'h000A, 1);
    n_tests++;
    if (sd_tr !== e_sd) begin
      n_fail++; $display("FAIL invert_sd: got %h expected %h", sd_tr, e_sd);
    end
    n_tests++;
    if (busy_tr !== e_busy) begin
      n_fail++; $display("FAIL invert_busy: got %h expected %h", busy_tr, e_busy);
    end
    n_tests++;
    if (done_tr !== e_done) begin
      n_fail++; $display("FAIL invert_done: got %h expected %h", done_tr, e_done);
    end
    n_tests++;
    if ((si_tr & si_mask) !== e_si) begin
      n_fail++; $display("FAIL invert_si: got %h expected %h", si_tr & si_mask, e_si);
    end
    n_tests++;
    if (bus4.CAP_DATA !== 4'b0101) begin
      n_fail++; $display("FAIL invert_cap: got %b expected 0101", bus4.CAP_DATA);
    end
  endtask

  task automatic test_const();
    mode4 = 1;
    k4    = 4'b0011;
    run_trace(N4, 16'h000F, 2*N4+4, '0);
    n_tests++;
    if (bus4.CAP_DATA !== 4'b0011) begin
      n_fail++; $display("FAIL const_cap: got %b expected 0011", bus4.CAP_DATA);
    end
    n_tests++;
    if (snap !== 16'h0000) begin
      n_fail++; $display("FAIL const_fill: chain got %h expected 0000", snap);
    end
  endtask

  task automatic test_random();
    logic [15:0] ld, exp_cap;
    for (int it = 0; it < 6; it++) begin
      mode4 = int'($urandom_range(2, 0));
      k4    = 4'($urandom);
      ld    = 16'(4'($urandom));
      exp_cap = 16'(4'(d0_fn(mode4, ld, 16'(k4))));
      run_trace(N4, ld, 2*N4+4, '0);
      build_exp(N4, ld, 1);
      n_tests++;
      if ({sd_tr, busy_tr, done_tr, si_tr & si_mask} !== {e_sd, e_busy, e_done, e_si}) begin
        n_fail++;
        $display("FAIL random_trace[%0d]: sd %h/%h busy %h/%h done %h/%h", it,
                 sd_tr, e_sd, busy_tr, e_busy, done_tr, e_done);
      end
      n_tests++;
      if (cap_of(N4) !== exp_cap || snap !== 16'h0000) begin
        n_fail++;
        $display("FAIL random_cap[%0d]: got cap %h chain %h expected cap %h chain 0000",
                 it, cap_of(N4), snap, exp_cap);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] ld;
    mode4 = 2;
    ld = 16'(4'($urandom));
    run_trace(N4, ld, 2*N4+8, 64'h44);
    build_exp(N4, ld, 1);
    n_tests++;
    if ({sd_tr, busy_tr, done_tr} !== {e_sd, e_busy, e_done}) begin
      n_fail++;
      $display("FAIL ignore_trace: sd %h/%h busy %h/%h done %h/%h",
               sd_tr, e_sd, busy_tr, e_busy, done_tr, e_done);
    end
    n_tests++;
    if ($countones(done_tr) != 1) begin
      n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", $countones(done_tr));
    end
    n_tests++;
    if (cap_of(N4) !== ld) begin
      n_fail++; $display("FAIL ignore_cap: got %h expected %h", cap_of(N4), ld);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ld;
    mode4 = 0;
    ld = 16'(4'($urandom));
    run_trace(N4, ld, 40, 64'hFFFF_FFFF);
    build_exp(N4, ld, 3);
    n_tests++;
    if (done_tr !== e_done) begin
      n_fail++; $display("FAIL b2b_done: got %h expected %h", done_tr, e_done);
    end
    n_tests++;
    if ({sd_tr, busy_tr} !== {e_sd, e_busy}) begin
      n_fail++;
      $display("FAIL b2b_sd_busy: sd %h/%h busy %h/%h", sd_tr, e_sd, busy_tr, e_busy);
    end
    n_tests++;
    if (cap_of(N4) !== 16'(4'(~ld))) begin
      n_fail++; $display("FAIL b2b_cap: got %h expected %h", cap_of(N4), 16'(4'(~ld)));
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ld;
    int dones;
    mode4 = 2;
    ld = 16'(4'($urandom) | 4'b1000);
    @(negedge CK);
    RN = 1'b0;
    #2 RN = 1'b1;
    @(negedge CK);
    drive(N4, 1'b1, ld);
    @(negedge CK);
    drive(N4, 1'b0, ld);
    repeat (7) @(negedge CK);
    n_tests++;
    if ({bus4.SD, bus4.BUSY} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_pre: sd/busy got %b expected 11", {bus4.SD, bus4.BUSY});
    end
    #2 RN = 1'b0;
    #1;
    n_tests++;
    if ({bus4.SD, bus4.BUSY} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_async: sd/busy got %b expected 00", {bus4.SD, bus4.BUSY});
    end
    #1 RN = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CK);
      if (bus4.DONE === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0 || bus4.CAP_DATA !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_nodone: got done %0d cap %b expected done 0 cap 0000",
               dones, bus4.CAP_DATA);
    end
    run_trace(N4, ld, 2*N4+4, '0);
    build_exp(N4, ld, 1);
    n_tests++;
    if (done_tr !== e_done || cap_of(N4) !== ld) begin
      n_fail++;
      $display("FAIL midrst_restart: done %h cap %h expected done %h cap %h",
               done_tr, cap_of(N4), e_done, ld);
    end
  endtask

  task automatic test_n16();
    logic [15:0] ld;
    mode16 = 2;
    run_trace(N16, 16'hA5C3, 2*N16+4, '0);
    build_exp(N16, 16'hA5C3, 1);
    n_tests++;
    if (si_tr[0] !== 1'b1) begin
      n_fail++; $display("FAIL n16_first_si: got %b expected 1", si_tr[0]);
    end
    n_tests++;
    if ({sd_tr, busy_tr, done_tr, si_tr & si_mask} !== {e_sd, e_busy, e_done, e_si}) begin
      n_fail++;
      $display("FAIL n16_trace: sd %h/%h busy %h/%h done %h/%h si %h/%h", sd_tr, e_sd,
               busy_tr, e_busy, done_tr, e_done, si_tr & si_mask, e_si);
    end
    n_tests++;
    if (bus16.CAP_DATA !== 16'hA5C3) begin
      n_fail++; $display("FAIL n16_cap: got %h expected a5c3", bus16.CAP_DATA);
    end
    for (int it = 0; it < 3; it++) begin
      mode16 = int'($urandom_range(1, 0));
      k16    = 16'($urandom);
      ld     = 16'($urandom);
      run_trace(N16, ld, 2*N16+4, '0);
      n_tests++;
      if (bus16.CAP_DATA !== d0_fn(mode16, ld, k16) || snap !== 16'h0000) begin
        n_fail++;
        $display("FAIL n16_random[%0d]: got cap %h chain %h expected cap %h chain 0000",
                 it, bus16.CAP_DATA, snap, d0_fn(mode16, ld, k16));
      end
    end
  endtask

  initial begin
    bus4.START = 1'b0;  bus4.LOAD_DATA = '0;
    bus16.START = 1'b0; bus16.LOAD_DATA = '0;
    test_reset();
    test_invert();
    test_const();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_n16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
